bit_serializer: RTL



---
 rtl/bit_serializer_pkg.sv | 23 ++
 rtl/bit_serializer_timer.sv | 52 +++++
 rtl/bit_serializer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer and its detector bench.
// Optional build macro: SER_LSB_FIRST_EN (LSB-first bit order).
package ser_pkg;

  // FSM state enumeration (1-bit encoding)
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // Legacy-compatible state constants used by the state register
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Default bit period in clk cycles, shared with the detector bench
  localparam int unsigned SER_BIT_PERIOD = 1;

  // Counter width for values 0..n-1, never less than one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_serializer_timer.sv
// ser_bit_timer: DIV-cycle bit-period divider.
// Ports: clk, rst_n; clr restarts the period; run keeps counting;
//        tick marks the last cycle of a period; tick_nxt predicts tick
//        for the next cycle so callers can register status outputs.
module ser_bit_timer
  import ser_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick,
  output logic tick_nxt
);

  generate
    if (DIV == 1) begin : g_one
      // Every cycle ends a bit period
      logic unused_in;
      assign unused_in = clr ^ run ^ clk ^ rst_n;
      assign tick      = 1'b1;
      assign tick_nxt  = 1'b1;
    end else begin : g_div
      localparam int unsigned DW = cnt_w(DIV);
      localparam logic [DW-1:0] LAST = DW'(DIV - 1);

      logic [DW-1:0] cnt;
      logic [DW-1:0] cnt_n;

      assign tick = (cnt == LAST);

      // Wrap only through the explicit compare against LAST
      always_comb begin
        cnt_n = '0;
        if (clr)
          cnt_n = '0;
        else if (run)
          cnt_n = tick ? '0 : cnt + DW'(1);
      end

      assign tick_nxt = (cnt_n == LAST);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt_n;
      end
    end
  endgenerate

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial feeder for the sequence detector.
// Ports: clk, rst_n (async active-low); din/din_valid/din_ready word
//        handshake; x serial bit; x_valid word bit present; busy while
//        shifting; done pulses in the final cycle of a word's last bit.
// Build macro SER_LSB_FIRST_EN selects LSB-first order (default MSB-first).
module bit_serializer
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = SER_BIT_PERIOD,
  parameter int unsigned CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [0:0]       state, state_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [CNT_W-1:0] idx, idx_n;
  logic             x_n, xv_n, rdy_n, done_n, busy_n;
  logic             xfer, load, tick, tick_nxt;

  assign xfer = din_valid && din_ready;

  ser_bit_timer #(.DIV(DIV)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (load),
    .run      (state == ST_SHIFT),
    .tick     (tick),
    .tick_nxt (tick_nxt)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_n = state;
    sh_n    = sh;
    idx_n   = idx;
    x_n     = x;
    xv_n    = x_valid;
    load    = 1'b0;

    case (state)
      ST_IDLE: begin
        x_n  = 1'b0;
        xv_n = 1'b0;
        if (xfer) load = 1'b1;
      end
      ST_SHIFT: begin
        if (tick) begin
          if (idx == LAST_BIT) begin
            if (xfer) begin
              load = 1'b1;
            end else begin
              state_n = ST_IDLE;
              x_n     = 1'b0;
              xv_n    = 1'b0;
            end
          end else begin
            idx_n = idx + CNT_W'(1);
            // Rotate so the next bit lands in the output position
`ifdef SER_LSB_FIRST_EN
            sh_n = {sh[0], sh[WIDTH-1:1]};
            x_n  = sh[1];
`else
            sh_n = {sh[WIDTH-2:0], sh[WIDTH-1]};
            x_n  = sh[WIDTH-2];
`endif
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        x_n     = 1'b0;
        xv_n    = 1'b0;
      end
    endcase

    if (load) begin
      state_n = ST_SHIFT;
      sh_n    = din;
      idx_n   = '0;
      xv_n    = 1'b1;
`ifdef SER_LSB_FIRST_EN
      x_n = din[0];
`else
      x_n = din[WIDTH-1];
`endif
    end

    // Predict next-cycle status so it can be registered
    done_n = (state_n == ST_SHIFT) && (idx_n == LAST_BIT) && tick_nxt;
    rdy_n  = (state_n == ST_IDLE) || done_n;
    busy_n = (state_n == ST_SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sh        <= '0;
      idx       <= '0;
      x         <= 1'b0;
      x_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      din_ready <= 1'b1;
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      idx       <= idx_n;
      x         <= x_n;
      x_valid   <= xv_n;
      busy      <= busy_n;
      done      <= done_n;
      din_ready <= rdy_n;
    end
  end

endmodule
